svr_vec_seq: RTL

- Parametrised successor to the scalar/vector register file: a vector register file written through a sequenced, back-pressured write port.
- A single write request carries a 1, 4 or 16 element vector. The block retires it over multiple cycles at WPC words per cycle. Register indices wrap modulo NREGS.
- Two combinational read ports and a per-register pending mask let execute-stage consumers detect in-flight writes and stall on them.

---
 rtl/svr_vec_seq.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/svr_vec_seq.sv
// svr_vec_seq: vector register file with a sequenced, back-pressured write port.
// A request of 1, 4 or 16 elements is buffered and retired WPC words per cycle,
// with register indices wrapping modulo NREGS. A per-register pending mask marks
// registers whose write has not yet landed.
// Optional macro SVR_VEC_SEQ_FWD_EN: read ports return the buffered element for
// pending registers instead of the (stale) array contents.
module svr_vec_seq #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int LANES = 16,
  parameter int WPC   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [1:0]               wr_vl,
  input  logic [$clog2(NREGS)-1:0] wr_addr,
  input  logic [LANES*XLEN-1:0]    wr_data,
  output logic                     wr_err,
  output logic                     busy,
  output logic [NREGS-1:0]         pending,
  input  logic [$clog2(NREGS)-1:0] ra0,
  input  logic [$clog2(NREGS)-1:0] ra1,
  output logic [XLEN-1:0]          rd0,
  output logic [XLEN-1:0]          rd1
);

  localparam int AW = $clog2(NREGS);
  // IW holds element indices and lengths up to LANES inclusive.
  localparam int IW = $clog2(LANES) + 1;
  // LW indexes one element of the beat buffer.
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  // Illegal configurations stop elaboration.
  if ((LANES % WPC) != 0) begin : g_bad_wpc
    $error("svr_vec_seq: WPC must divide LANES");
  end
  if (NREGS < LANES) begin : g_bad_nregs
    $error("svr_vec_seq: NREGS must be at least LANES");
  end
  if (LANES < 16) begin : g_bad_lanes
    $error("svr_vec_seq: LANES must cover the 16-element length code");
  end

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [XLEN-1:0]       r_regs [NREGS];
  logic [LANES*XLEN-1:0] r_buf;
  logic [AW-1:0]         r_base;
  logic [IW-1:0]         r_len;
  logic [IW-1:0]         r_beat;
  logic                  r_err;
  logic [NREGS-1:0]      r_pending;

  logic                  w_accept;
  logic                  w_reserved;
  logic                  w_start;
  logic                  w_last_beat;
  logic [IW-1:0]         w_len_in;
  logic [IW-1:0]         w_beat_base;
  logic [NREGS-1:0]      w_set_mask;
  logic [NREGS-1:0]      w_clr_mask;
  logic [IW-1:0]         w_idx   [WPC];
  logic                  w_wen   [WPC];
  logic [AW-1:0]         w_waddr [WPC];
  logic [XLEN-1:0]       w_wdata [WPC];

  assign w_reserved  = w_accept && (wr_vl == 2'b11);
  assign w_start     = w_accept && (wr_vl != 2'b11);
  assign w_beat_base = r_beat * IW'(WPC);
  // The current beat is the last one once its upper element bound reaches len.
  assign w_last_beat = (w_beat_base + IW'(WPC)) >= r_len;

  // Decode the length code; the reserved code never reaches the buffer.
  always_comb begin
    case (wr_vl)
      2'b00:   w_len_in = IW'(1);
      2'b01:   w_len_in = IW'(4);
      default: w_len_in = IW'(16);
    endcase
  end

  // Next-state and handshake outputs of the IDLE/WRITE sequencer.
  always_comb begin
    w_state_next = r_state;
    wr_ready     = 1'b0;
    busy         = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        wr_ready = 1'b1;
        w_accept = wr_valid;
        if (w_start) w_state_next = S_WRITE;
      end
      S_WRITE: begin
        busy = 1'b1;
        if (w_last_beat) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // One write lane per word retired each cycle; lanes past len stay idle.
  for (genvar gi = 0; gi < WPC; gi++) begin : g_lane
    assign w_idx[gi]   = w_beat_base + IW'(gi);
    assign w_wen[gi]   = (r_state == S_WRITE) && (w_idx[gi] < r_len);
    assign w_waddr[gi] = r_base + AW'(w_idx[gi]);
    assign w_wdata[gi] = r_buf[XLEN*LW'(w_idx[gi]) +: XLEN];
  end

  // Latch the request on acceptance and step the beat counter while writing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf  <= '0;
      r_base <= '0;
      r_len  <= '0;
      r_beat <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_reserved;
      if (w_start) begin
        r_buf  <= wr_data;
        r_base <= wr_addr;
        r_len  <= w_len_in;
        r_beat <= '0;
      end else if (r_state == S_WRITE) begin
        r_beat <= r_beat + IW'(1);
      end
    end
  end

  // Pending bits to raise for a newly accepted request (wrapping addresses).
  always_comb begin
    w_set_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_start && (IW'(i) < w_len_in)) w_set_mask[wr_addr + AW'(i)] = 1'b1;
    end
  end

  // Pending bits to drop: exactly the registers written on this edge.
  always_comb begin
    w_clr_mask = '0;
    for (int j = 0; j < WPC; j++) begin
      if (w_wen[j]) w_clr_mask[w_waddr[j]] = 1'b1;
    end
  end

  // Pending mask; set and clear never coincide since acceptance is IDLE-only.
  always_ff @(posedge clk) begin
    if (rst) r_pending <= '0;
    else     r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
  end

  // Register array: cleared on reset, written up to WPC words per beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) r_regs[r] <= '0;
    end else begin
      for (int j = 0; j < WPC; j++) begin
        if (w_wen[j]) r_regs[w_waddr[j]] <= w_wdata[j];
      end
    end
  end

  assign wr_err  = r_err;
  assign pending = r_pending;

`ifdef SVR_VEC_SEQ_FWD_EN
  // A pending register's element offset from the buffered base address.
  logic [LW-1:0] w_fidx0;
  logic [LW-1:0] w_fidx1;
  assign w_fidx0 = LW'(ra0 - r_base);
  assign w_fidx1 = LW'(ra1 - r_base);
  assign rd0 = r_pending[ra0] ? r_buf[XLEN*w_fidx0 +: XLEN] : r_regs[ra0];
  assign rd1 = r_pending[ra1] ? r_buf[XLEN*w_fidx1 +: XLEN] : r_regs[ra1];
`else
  assign rd0 = r_regs[ra0];
  assign rd1 = r_regs[ra1];
`endif

endmodule
